oled_pattern_gen: RTL and testbench

OLED_PATTERN_GEN -- requirements
Module: oled_pattern_gen

---
 rtl/oled_pattern_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/oled_pattern_gen.sv | 125 ++++++++++++
 tb/tb_oled_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pattern_pkg.sv
// Shared definitions for the OLED test-pattern generator: pattern modes,
// panel geometry and full-scale colour constants for both pixel formats.
package oled_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_CHECKER = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_GREY    = 3'd2,
        MODE_SCROLL  = 3'd3,
        MODE_WHITE   = 3'd4,
        MODE_BORDER  = 3'd5
    } mode_e;

    localparam int MODE_COUNT = 6;
    localparam int PANEL_W    = 96;
    localparam int PANEL_H    = 64;

    localparam logic [15:0] WHITE_565 = 16'hFFFF;
    localparam logic [15:0] BLACK_565 = 16'h0000;
    localparam logic [7:0]  WHITE_332 = 8'hFF;
    localparam logic [7:0]  BLACK_332 = 8'h00;

    function automatic mode_e mode_next(input mode_e m);
        if (int'(m) == MODE_COUNT - 1) begin
            return MODE_CHECKER;
        end else begin
            return mode_e'(m + 3'd1);
        end
    endfunction

    function automatic mode_e mode_prev(input mode_e m);
        if (m == MODE_CHECKER) begin
            return mode_e'(3'(MODE_COUNT - 1));
        end else begin
            return mode_e'(m - 3'd1);
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, saturating-count debouncer and a
// one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
    parameter int C_bits = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pressed
);

    logic              sync1_q, sync2_q;
    logic              state_q, state_d, state_prev_q;
    logic [C_bits-1:0] cnt_q, cnt_d;

    // The counter only advances while the input disagrees with the debounced
    // level; any agreement restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        if (sync2_q != state_q) begin
            if (cnt_q == '1) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + C_bits'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= 1'b0;
            state_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            state_prev_q <= state_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pressed = state_q & ~state_prev_q;

endmodule

// File: rtl/oled_pattern_gen.sv
// Test-pattern source for a 96x64 OLED: button-selected pattern mode, frame
// detection from the driver's scan coordinates and a registered pixel colour.
module oled_pattern_gen
    import oled_pattern_pkg::*;
#(
    parameter int C_color_bits    = 16,
    parameter int C_x_bits        = 7,
    parameter int C_y_bits        = 6,
    parameter int C_debounce_bits = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_next,
    input  logic                    btn_prev,
    input  logic [C_x_bits-1:0]     x,
    input  logic [C_y_bits-1:0]     y,
    output logic [C_color_bits-1:0] color,
    output logic [2:0]              mode,
    output logic                    frame_tick
);

    logic                         press_next, press_prev;
    mode_e                        mode_q, mode_d;
    logic [C_x_bits+C_y_bits-1:0] coord_prev_q;
    logic                         frame_start;
    logic                         frame_tick_q;
    logic [7:0]                   frame_cnt_q;
    logic                         is_border;
    logic [C_color_bits-1:0]      color_d, color_q;

    btn_debounce #(.C_bits(C_debounce_bits)) u_db_next (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_next),
        .pressed (press_next)
    );

    btn_debounce #(.C_bits(C_debounce_bits)) u_db_prev (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn_prev),
        .pressed (press_prev)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_CHECKER;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Opposing presses in the same cycle cancel out.
    always_comb begin
        mode_d = mode_q;
        if (press_next && !press_prev) begin
            mode_d = mode_next(mode_q);
        end else if (press_prev && !press_next) begin
            mode_d = mode_prev(mode_q);
        end
    end

    // coord_prev_q resets to all-ones so a (0,0) straight out of reset counts.
    assign frame_start = ({x, y} == '0) && (coord_prev_q != '0);

    assign is_border = (x == '0) || (x == C_x_bits'(PANEL_W - 1)) ||
                       (y == '0) || (y == C_y_bits'(PANEL_H - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            coord_prev_q <= '1;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            color_q      <= '0;
        end else begin
            coord_prev_q <= {x, y};
            frame_tick_q <= frame_start;
            if (frame_start) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            color_q <= color_d;
        end
    end

    generate
        if (C_color_bits == 16) begin : g_rgb565
            logic [5:0] cx6;
            always_comb begin
                cx6 = (mode_q == MODE_SCROLL)
                    ? 6'((x + C_x_bits'(frame_cnt_q[6:0])) >> 1) : x[6:1];
                color_d = BLACK_565;
                case (mode_q)
                    MODE_CHECKER, MODE_SCROLL:
                        color_d = (cx6[2] ^ y[3]) ? {5'd0, cx6, 5'd0} : {y[5:1], 11'd0};
                    MODE_BARS:   color_d = {{5{x[6]}}, {6{x[5]}}, {5{x[4]}}};
                    MODE_GREY:   color_d = {x[6:2], x[6:2], x[6], x[6:2]};
                    MODE_WHITE:  color_d = WHITE_565;
                    MODE_BORDER: color_d = is_border ? WHITE_565 : BLACK_565;
                    default:     color_d = BLACK_565;
                endcase
            end
        end else begin : g_rgb332
            logic [3:0] cx4;
            always_comb begin
                cx4 = (mode_q == MODE_SCROLL)
                    ? 4'((x + C_x_bits'(frame_cnt_q[6:0])) >> 3) : x[6:3];
                color_d = BLACK_332;
                case (mode_q)
                    MODE_CHECKER, MODE_SCROLL:
                        color_d = (cx4[0] ^ y[3]) ? {3'd0, cx4[3:1], 2'd0} : {y[5:3], 5'd0};
                    MODE_BARS:   color_d = {{3{x[6]}}, {3{x[5]}}, {2{x[4]}}};
                    MODE_GREY:   color_d = {x[6:4], x[6:4], x[6:5]};
                    MODE_WHITE:  color_d = WHITE_332;
                    MODE_BORDER: color_d = is_border ? WHITE_332 : BLACK_332;
                    default:     color_d = BLACK_332;
                endcase
            end
        end
    endgenerate

    assign color      = color_q;
    assign mode       = mode_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_oled_pattern_gen.sv
// Bench for oled_pattern_gen: RGB565 and RGB332 builds side by side, driven by
// directed button and coordinate sequences and checked against a pixel model.
module tb_oled_pattern_gen;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic [6:0]  x        = '0;
    logic [5:0]  y        = '0;
    logic [15:0] color16;
    logic [7:0]  color8;
    logic [2:0]  mode16, mode8;
    logic        tick16, tick8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;
    int exp_mode = 0;
    int mdl_frame = 0;
    bit mdl_prev_zero = 1'b0;

    int corner_x[8] = '{0, 95, 96, 127, 8, 7, 16, 112};
    int corner_y[8] = '{0, 63, 0, 63, 8, 15, 40, 5};

    always #5 clk = ~clk;

    oled_pattern_gen #(
        .C_color_bits(16), .C_x_bits(7), .C_y_bits(6), .C_debounce_bits(4)
    ) dut16 (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .x(x), .y(y), .color(color16), .mode(mode16), .frame_tick(tick16)
    );

    oled_pattern_gen #(
        .C_color_bits(8), .C_x_bits(7), .C_y_bits(6), .C_debounce_bits(4)
    ) dut8 (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .x(x), .y(y), .color(color8), .mode(mode8), .frame_tick(tick8)
    );

    // Pixel model: work out channel intensities, then pack into the format.
    function automatic logic [15:0] pix16(input int px, input int py, input int m, input int f);
        int r, g, b, cx, bar, i;
        r = 0; g = 0; b = 0; cx = px;
        if (m == 3) cx = (px + (f % 128)) % 128;
        case (m)
            0, 3: if ((((cx >> 3) ^ (py >> 3)) & 1) == 1) g = (cx >> 1) & 63;
                  else r = (py >> 1) & 31;
            1: begin
                bar = (px >> 4) & 7;
                if ((bar & 4) != 0) r = 31;
                if ((bar & 2) != 0) g = 63;
                if ((bar & 1) != 0) b = 31;
            end
            2: begin i = (px >> 2) & 31; r = i; g = (i << 1) | (i >> 4); b = i; end
            4: begin r = 31; g = 63; b = 31; end
            5: if (px == 0 || px == 95 || py == 0 || py == 63) begin r = 31; g = 63; b = 31; end
            default: ;
        endcase
        return 16'((r << 11) | (g << 5) | b);
    endfunction

    function automatic logic [7:0] pix8(input int px, input int py, input int m, input int f);
        int r, g, b, cx, bar, i;
        r = 0; g = 0; b = 0; cx = px;
        if (m == 3) cx = (px + (f % 128)) % 128;
        case (m)
            0, 3: if ((((cx >> 3) ^ (py >> 3)) & 1) == 1) g = (cx >> 4) & 7;
                  else r = (py >> 3) & 7;
            1: begin
                bar = (px >> 4) & 7;
                if ((bar & 4) != 0) r = 7;
                if ((bar & 2) != 0) g = 7;
                if ((bar & 1) != 0) b = 3;
            end
            2: begin i = (px >> 2) & 31; r = i >> 2; g = i >> 2; b = i >> 3; end
            4: begin r = 7; g = 7; b = 3; end
            5: if (px == 0 || px == 95 || py == 0 || py == 63) begin r = 7; g = 7; b = 3; end
            default: ;
        endcase
        return 8'((r << 5) | (g << 2) | b);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model advances on each rising edge, outputs sampled 1 ns later.
    initial begin : compare
        logic [15:0] e16;
        logic [7:0]  e8;
        bit          etick, en, rs, zero;
        int          em;
        forever begin
            @(posedge clk);
            rs = reset;
            en = chk_en;
            em = exp_mode;
            if (rs) begin
                e16 = '0; e8 = '0; etick = 1'b0;
                mdl_frame = 0; mdl_prev_zero = 1'b0;
            end else begin
                zero  = (x == 0) && (y == 0);
                etick = zero && !mdl_prev_zero;
                e16   = pix16(int'(x), int'(y), em, mdl_frame);
                e8    = pix8(int'(x), int'(y), em, mdl_frame);
                if (etick) mdl_frame = (mdl_frame + 1) % 256;
                mdl_prev_zero = zero;
            end
            #1;
            check("tick16", tick16, etick);
            check("tick8", tick8, etick);
            if (rs || en) begin
                check("color16", color16, e16);
                check("color8", color8, e8);
                check("mode16", mode16, rs ? 0 : em);
                check("mode8", mode8, rs ? 0 : em);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; x = 7'd5; y = 6'd0; exp_mode = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pin16(input int px, input int py, input logic [15:0] want, input string nm);
        @(negedge clk);
        x = 7'(px); y = 6'(py);
        @(posedge clk);
        #1;
        check(nm, color16, want);
    endtask

    task automatic pin8(input int px, input int py, input logic [7:0] want, input string nm);
        @(negedge clk);
        x = 7'(px); y = 6'(py);
        @(posedge clk);
        #1;
        check(nm, color8, want);
    endtask

    task automatic scan();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x = 7'((i * 37 + 3) % 128);
            y = 6'((i * 23 + 5) % 64);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x = 7'(corner_x[i]);
            y = 6'(corner_y[i]);
        end
        @(negedge clk);
        x = 7'd5; y = 6'd5;
    endtask

    task automatic press(input bit nx, input bit pv, input int hold, input int want, input string nm);
        @(negedge clk);
        chk_en = 1'b0;
        btn_next = nx; btn_prev = pv;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0; btn_prev = 1'b0;
        repeat (40) @(negedge clk);
        exp_mode = want;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check({nm, "_mode16"}, mode16, want);
        check({nm, "_mode8"}, mode8, want);
    endtask

    initial begin : main
        int          ticks;
        logic [15:0] origin_f2;
        ticks = 0;
        origin_f2 = '0;

        repeat (3) @(negedge clk);
        do_reset();
        pin16(5, 0, 16'h0000, "m0_x5y0");
        pin16(8, 0, 16'h0080, "m0_x8y0");
        pin8(8, 8, 8'h20, "m0_8b_x8y8");
        scan();

        press(1'b1, 1'b0, 20, 1, "next1");
        pin16(112, 0, 16'hFFFF, "m1_bar7");
        pin16(32, 0, 16'h07E0, "m1_bar2");
        pin8(16, 0, 8'h03, "m1_8b_bar1");
        scan();

        for (int k = 2; k <= 6; k++) begin
            press(1'b1, 1'b0, 20, k % 6, "next_step");
            if (k == 2) begin
                pin16(64, 0, 16'h8430, "m2_grey64");
                pin8(64, 0, 8'h92, "m2_8b_grey64");
                pin16(127, 0, 16'hFFFF, "m2_grey127");
            end
            if (k == 4) pin8(50, 30, 8'hFF, "m4_8b_white");
            if (k == 5) begin
                pin16(95, 10, 16'hFFFF, "m5_right_edge");
                pin16(96, 10, 16'h0000, "m5_past_edge");
            end
            scan();
        end

        press(1'b0, 1'b1, 3, 0, "prev_glitch");
        press(1'b0, 1'b1, 20, 5, "prev_wrap");
        pin16(10, 63, 16'hFFFF, "m5_bottom");
        pin16(50, 30, 16'h0000, "m5_inner");
        press(1'b1, 1'b1, 20, 5, "both");

        // Reset lands mid-way through a debounce window and must discard it.
        @(negedge clk);
        chk_en = 1'b0; x = 7'd5; y = 6'd5; btn_next = 1'b1;
        repeat (12) @(negedge clk);
        reset = 1'b1; exp_mode = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        btn_next = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_discard_mode", mode16, 0);

        press(1'b1, 1'b0, 20, 1, "to_scroll_a");
        press(1'b1, 1'b0, 20, 2, "to_scroll_b");
        press(1'b1, 1'b0, 20, 3, "to_scroll_c");

        for (int f = 0; f < 3; f++) begin
            for (int yy = 0; yy < 64; yy++) begin
                for (int xx = 0; xx < 96; xx++) begin
                    @(negedge clk);
                    x = 7'(xx); y = 6'(yy);
                    @(posedge clk);
                    #1;
                    if (tick16) ticks++;
                    if (f == 2 && xx == 0 && yy == 0) origin_f2 = color16;
                end
            end
        end
        check("frame_ticks", ticks, 3);
        check("scroll_f2_origin", origin_f2, pix16(2, 0, 0, 0));
        pin16(5, 0, 16'h0080, "m3_shift3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
